// File: rtl/noc_link_pkg.sv
// noc_link_pkg: shared flit type, link widths and dest split helpers
package noc_link_pkg;
   localparam int TID_WIDTH   = 2;
   localparam int TDEST_WIDTH = 4;
   localparam int TDATA_WIDTH = 32;
   localparam int DEST_WIDTH  = TDEST_WIDTH + TID_WIDTH;
   typedef struct packed {
      logic [TDATA_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0]  dest;
      logic                   is_tail;
   } flit_t;
   function automatic logic [TID_WIDTH-1:0] get_tid(input logic [DEST_WIDTH-1:0] dest);
      return dest[DEST_WIDTH-1:TDEST_WIDTH];
   endfunction
   function automatic logic [TDEST_WIDTH-1:0] get_tdest(input logic [DEST_WIDTH-1:0] dest);
      return dest[TDEST_WIDTH-1:0];
   endfunction
endpackage

// File: rtl/noc_flit_ejector_if.sv
// noc_flit_ejector_if: credit flit link in, AXI-Stream beat out
interface noc_flit_ejector_if;
   import noc_link_pkg::*;
   logic [TDATA_WIDTH-1:0] data_in;
   logic [DEST_WIDTH-1:0]  dest_in;
   logic                   is_tail_in;
   logic                   send_in;
   logic                   credit_out;
   logic                   axis_out_tvalid;
   logic                   axis_out_tready;
   logic [TDATA_WIDTH-1:0] axis_out_tdata;
   logic                   axis_out_tlast;
   logic [TID_WIDTH-1:0]   axis_out_tid;
   logic [TDEST_WIDTH-1:0] axis_out_tdest;
   modport master (
      input  data_in, dest_in, is_tail_in, send_in, axis_out_tready,
      output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest
   );
   modport slave (
      output data_in, dest_in, is_tail_in, send_in, axis_out_tready,
      input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast, axis_out_tid, axis_out_tdest
   );
endinterface

// File: rtl/noc_flit_ejector_flit_fifo.sv
// flit_fifo: synchronous flit FIFO with wrap-bit pointers, registered-state read port
module flit_fifo
   import noc_link_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  flit_t wr_flit,
   input  logic  pop,
   output flit_t rd_flit,
   output logic  empty,
   output logic  full
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_ptr, rd_ptr;
   logic        do_push, do_pop;
   flit_t       mem [DEPTH];
   // status and head-of-queue view, all from registered pointers and storage
   always_comb begin
      empty   = wr_ptr == rd_ptr;
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_push = push && !full;
      do_pop  = pop && !empty;
      rd_flit = mem[rd_ptr[AW-1:0]];
   end
   // pointer advance; a push into a full buffer is simply ignored here
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   // storage has no reset; contents only matter between the pointers
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_flit;
   end
endmodule

// File: rtl/noc_flit_ejector.sv
// noc_flit_ejector: buffers credit-link flits and drains them as an AXI-Stream master
module noc_flit_ejector
   import noc_link_pkg::*;
#(
   parameter int FLIT_BUFFER_DEPTH = 8,
   parameter int PKT_CNT_WIDTH     = 16
) (
   input  logic                     clk_noc,
   input  logic                     rst_n,
   noc_flit_ejector_if.master       link,
   output logic                     overflow,
   output logic [PKT_CNT_WIDTH-1:0] pkt_count
);
   flit_t in_flit, head;
   logic  empty, full, pop;
   flit_fifo #(.DEPTH(FLIT_BUFFER_DEPTH)) u_fifo (
      .clk     (clk_noc),
      .rst_n   (rst_n),
      .push    (link.send_in),
      .wr_flit (in_flit),
      .pop     (pop),
      .rd_flit (head),
      .empty   (empty),
      .full    (full)
   );
   // AXIS mapping of the buffer head; tvalid depends only on registered pointers
   always_comb begin
      in_flit              = '{data: link.data_in, dest: link.dest_in, is_tail: link.is_tail_in};
      link.axis_out_tvalid = !empty;
      link.axis_out_tdata  = head.data;
      link.axis_out_tlast  = head.is_tail;
      link.axis_out_tid    = get_tid(head.dest);
      link.axis_out_tdest  = get_tdest(head.dest);
      pop                  = !empty && link.axis_out_tready;
   end
   // one credit per drained beat, sticky overflow, delivered-packet counter
   always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
         link.credit_out <= 1'b0;
         overflow        <= 1'b0;
         pkt_count       <= '0;
      end else begin
         link.credit_out <= pop;
         if (link.send_in && full) overflow <= 1'b1;
         if (pop && head.is_tail) pkt_count <= pkt_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_noc_flit_ejector.sv
// tb_noc_flit_ejector: directed scenario tasks plus a credit-tracking streaming run
module tb_noc_flit_ejector;
   import noc_link_pkg::*;
   logic        clk_noc = 1'b0;
   logic        rst_n;
   logic        overflow;
   logic [15:0] pkt_count;
   int          vectors = 0;
   int          miscompares = 0;
   noc_flit_ejector_if bus ();
   noc_flit_ejector #(.FLIT_BUFFER_DEPTH(8), .PKT_CNT_WIDTH(16)) dut (
      .clk_noc   (clk_noc),
      .rst_n     (rst_n),
      .link      (bus.master),
      .overflow  (overflow),
      .pkt_count (pkt_count)
   );
   always #5 clk_noc = ~clk_noc;
   task automatic tick();
      @(posedge clk_noc);
      #1;
   endtask
   task automatic push_flits(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         bus.send_in    = 1'b1;
         bus.data_in    = base + 32'(i);
         bus.dest_in    = 6'(i);
         bus.is_tail_in = (i == n - 1);
         tick();
      end
      bus.send_in = 1'b0;
   endtask
   task automatic test_reset();
      rst_n               = 1'b0;
      bus.send_in         = 1'b1;
      bus.data_in         = 32'h55;
      bus.dest_in         = '0;
      bus.is_tail_in      = 1'b1;
      bus.axis_out_tready = 1'b1;
      repeat (3) tick();
      vectors++;
      if (bus.axis_out_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b expected 0", bus.axis_out_tvalid); end
      vectors++;
      if (bus.credit_out !== 1'b0) begin miscompares++; $display("FAIL reset_credit: got %b expected 0", bus.credit_out); end
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      vectors++;
      if (pkt_count !== 16'd0) begin miscompares++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
      rst_n       = 1'b1;
      bus.send_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (bus.axis_out_tvalid !== 1'b0 || bus.credit_out !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got tvalid=%b credit=%b expected 0/0", bus.axis_out_tvalid, bus.credit_out);
         end
      end
   endtask
   task automatic test_single_packet();
      int credits = 0;
      bus.axis_out_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.send_in    = 1'b1;
         bus.data_in    = 32'hA0 + 32'(i);
         bus.dest_in    = 6'h2B;
         bus.is_tail_in = (i == 3);
         tick();
         credits += int'(bus.credit_out);
         vectors++;
         if (bus.axis_out_tvalid !== 1'b1 || bus.axis_out_tdata !== 32'hA0 + 32'(i) || bus.axis_out_tlast !== (i == 3)
             || bus.axis_out_tid !== 2'd2 || bus.axis_out_tdest !== 4'hB) begin
            miscompares++;
            $display("FAIL single_beat%0d: got v=%b d=%h l=%b tid=%h tdest=%h expected 1/%h/%b/2/b", i, bus.axis_out_tvalid,
                     bus.axis_out_tdata, bus.axis_out_tlast, bus.axis_out_tid, bus.axis_out_tdest, 32'hA0 + 32'(i), i == 3);
         end
      end
      bus.send_in = 1'b0;
      tick();
      credits += int'(bus.credit_out);
      vectors++;
      if (bus.axis_out_tvalid !== 1'b0) begin miscompares++; $display("FAIL single_drained: got tvalid=%b expected 0", bus.axis_out_tvalid); end
      vectors++;
      if (pkt_count !== 16'd1) begin miscompares++; $display("FAIL single_pkt_count: got %0d expected 1", pkt_count); end
      repeat (2) begin
         tick();
         credits += int'(bus.credit_out);
      end
      vectors++;
      if (credits != 4) begin miscompares++; $display("FAIL single_credits: got %0d expected 4", credits); end
   endtask
   task automatic test_backpressure();
      bus.axis_out_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.send_in    = 1'b1;
         bus.data_in    = 32'hB0 + 32'(i);
         bus.dest_in    = 6'(i);
         bus.is_tail_in = (i == 7);
         tick();
         vectors++;
         if (bus.credit_out !== 1'b0 || bus.axis_out_tvalid !== 1'b1 || bus.axis_out_tdata !== 32'hB0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got credit=%b v=%b d=%h expected 0/1/b0", i, bus.credit_out, bus.axis_out_tvalid, bus.axis_out_tdata);
         end
      end
      bus.send_in = 1'b0;
      tick();
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL bp_no_overflow: got %b expected 0", overflow); end
      bus.axis_out_tready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (bus.axis_out_tvalid !== 1'b1 || bus.axis_out_tdata !== 32'hB0 + 32'(k)) begin
            miscompares++;
            $display("FAIL bp_beat%0d: got v=%b d=%h expected 1/%h", k, bus.axis_out_tvalid, bus.axis_out_tdata, 32'hB0 + 32'(k));
         end
         tick();
         vectors++;
         if (bus.credit_out !== 1'b1) begin miscompares++; $display("FAIL bp_credit%0d: got %b expected 1", k, bus.credit_out); end
      end
      vectors++;
      if (bus.axis_out_tvalid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %b expected 0", bus.axis_out_tvalid); end
      tick();
      vectors++;
      if (bus.credit_out !== 1'b0 || pkt_count !== 16'd2) begin
         miscompares++;
         $display("FAIL bp_end: got credit=%b pkt=%0d expected 0/2", bus.credit_out, pkt_count);
      end
   endtask
   task automatic test_overflow();
      bus.axis_out_tready = 1'b0;
      push_flits(32'hC0, 8);
      bus.send_in    = 1'b1;
      bus.data_in    = 32'hFF;
      bus.is_tail_in = 1'b0;
      tick();
      bus.send_in = 1'b0;
      vectors++;
      if (overflow !== 1'b1 || bus.axis_out_tdata !== 32'hC0) begin
         miscompares++;
         $display("FAIL ovf_set: got ovf=%b d=%h expected 1/c0", overflow, bus.axis_out_tdata);
      end
      tick();
      vectors++;
      if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      bus.axis_out_tready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (bus.axis_out_tvalid !== 1'b1 || bus.axis_out_tdata !== 32'hC0 + 32'(k)) begin
            miscompares++;
            $display("FAIL ovf_beat%0d: got v=%b d=%h expected 1/%h", k, bus.axis_out_tvalid, bus.axis_out_tdata, 32'hC0 + 32'(k));
         end
         tick();
      end
      vectors++;
      if (bus.axis_out_tvalid !== 1'b0 || pkt_count !== 16'd3 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_end: got v=%b pkt=%0d ovf=%b expected 0/3/1", bus.axis_out_tvalid, pkt_count, overflow);
      end
   endtask
   task automatic test_full_pop_push();
      rst_n = 1'b0;
      tick();
      rst_n               = 1'b1;
      bus.axis_out_tready = 1'b0;
      push_flits(32'hD0, 8);
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_clean: got %b expected 0", overflow); end
      vectors++;
      if (bus.axis_out_tdata !== 32'hD0) begin miscompares++; $display("FAIL fpp_head: got %h expected d0", bus.axis_out_tdata); end
      bus.axis_out_tready = 1'b1;
      bus.send_in         = 1'b1;
      bus.data_in         = 32'hEE;
      bus.is_tail_in      = 1'b0;
      tick();
      bus.send_in = 1'b0;
      vectors++;
      if (overflow !== 1'b1 || bus.credit_out !== 1'b1 || bus.axis_out_tdata !== 32'hD1) begin
         miscompares++;
         $display("FAIL fpp_edge: got ovf=%b credit=%b d=%h expected 1/1/d1", overflow, bus.credit_out, bus.axis_out_tdata);
      end
      for (int k = 1; k < 8; k++) begin
         vectors++;
         if (bus.axis_out_tvalid !== 1'b1 || bus.axis_out_tdata !== 32'hD0 + 32'(k)) begin
            miscompares++;
            $display("FAIL fpp_beat%0d: got v=%b d=%h expected 1/%h", k, bus.axis_out_tvalid, bus.axis_out_tdata, 32'hD0 + 32'(k));
         end
         tick();
      end
      vectors++;
      if (bus.axis_out_tvalid !== 1'b0 || pkt_count !== 16'd1) begin
         miscompares++;
         $display("FAIL fpp_end: got v=%b pkt=%0d expected 0/1", bus.axis_out_tvalid, pkt_count);
      end
   endtask
   task automatic test_streaming();
      int credits = 8;
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      rst_n       = 1'b0;
      bus.send_in = 1'b0;
      tick();
      rst_n = 1'b1;
      while (recv < 1000 && cyc < 20000) begin
         credits += int'(bus.credit_out);
         bus.axis_out_tready = 1'($urandom_range(0, 1));
         if (bus.axis_out_tvalid && bus.axis_out_tready) begin
            vectors++;
            if (bus.axis_out_tdata !== 32'(recv) || bus.axis_out_tlast !== (recv % 4 == 3)) begin
               miscompares++;
               $display("FAIL stream_beat%0d: got d=%h l=%b expected %h/%b", recv, bus.axis_out_tdata, bus.axis_out_tlast,
                        32'(recv), recv % 4 == 3);
            end
            recv++;
         end
         if (credits > 0 && sent < 1000 && $urandom_range(0, 3) != 0) begin
            bus.send_in    = 1'b1;
            bus.data_in    = 32'(sent);
            bus.dest_in    = 6'(sent);
            bus.is_tail_in = (sent % 4 == 3);
            credits--;
            sent++;
         end else bus.send_in = 1'b0;
         tick();
         cyc++;
      end
      bus.send_in         = 1'b0;
      bus.axis_out_tready = 1'b0;
      credits += int'(bus.credit_out);
      tick();
      credits += int'(bus.credit_out);
      vectors++;
      if (recv != 1000) begin miscompares++; $display("FAIL stream_timeout: got %0d beats expected 1000", recv); end
      vectors++;
      if (overflow !== 1'b0) begin miscompares++; $display("FAIL stream_overflow: got %b expected 0", overflow); end
      vectors++;
      if (pkt_count !== 16'd250) begin miscompares++; $display("FAIL stream_pkt_count: got %0d expected 250", pkt_count); end
      vectors++;
      if (credits != 8) begin miscompares++; $display("FAIL stream_credits: got %0d expected 8", credits); end
   endtask
   initial begin
      test_reset();
      test_single_packet();
      test_backpressure();
      test_overflow();
      test_full_pop_push();
      test_streaming();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/noc_flit_ejector.md
# noc_flit_ejector

Receive side of the NoC credit-based flit link: accepts flits (data, dest, is_tail, send) from a router output port, buffers them, presents them as an AXI-Stream master, and returns one credit per drained flit. Sits between a router output (typically the local ejection port) and a user AXI-Stream sink in the NoC clock domain, for unserialized links (flit = full beat). Also keeps a sticky overflow flag and a packet counter for debug.

## Interface
- FLIT_BUFFER_DEPTH, 8: buffer slots; equals the initial credit count held by the upstream sender; power of two, >= 2.
- TID_WIDTH, 2: tid field width.
- TDEST_WIDTH, 4: tdest field width.
- TDATA_WIDTH, 32: flit/beat data width.
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH: link dest width, packed as {tid, tdest}.
- PKT_CNT_WIDTH, 16: packet counter width.

Ports (one clock; reset is synchronous and active-low):
- clk_noc  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  TDATA_WIDTH  flit payload.
- dest_in  in  DEST_WIDTH  flit destination {tid, tdest}.
- is_tail_in  in  1  last flit of packet.
- send_in  in  1  flit valid this cycle (one-cycle qualifier, no backpressure).
- credit_out  out  1  one-cycle pulse = one slot freed.
- axis_out_tvalid  out  1  beat valid.
- axis_out_tready  in  1  sink ready.
- axis_out_tdata  out  TDATA_WIDTH  beat data.
- axis_out_tlast  out  1  = stored is_tail.
- axis_out_tid  out  TID_WIDTH  = stored dest[DEST_WIDTH-1:TDEST_WIDTH].
- axis_out_tdest  out  TDEST_WIDTH  = stored dest[TDEST_WIDTH-1:0].
- overflow  out  1  sticky: flit arrived with buffer full.
- pkt_count  out  PKT_CNT_WIDTH  packets fully delivered (tlast beats accepted).

## Operation
- Push: send_in=1 and count<DEPTH -> write {data, dest, is_tail} at wr_ptr, wr_ptr++.
- Push with count==DEPTH -> flit dropped, overflow set, even if a pop occurs the same cycle (upstream credit protocol cannot legally reach this state).
- Pop: axis_out_tvalid && axis_out_tready -> rd_ptr++, credit_out=1 next cycle.
- Pointers log2(DEPTH)+1 bits; wrap naturally; full = MSBs differ, low bits equal; empty = equal.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both succeed.
- Push into empty buffer: no bypass; beat appears next cycle.
- axis_out_* payload held stable while tvalid && !tready (AXI-Stream rule).
- pkt_count increments on accepted beat with tlast=1; wraps modulo 2^PKT_CNT_WIDTH.
- overflow cleared only by reset.
- No packet state machine: flits are forwarded in arrival order; packet integrity is upstream's responsibility.

## Timing
- Reset (rst_n=0 at an edge): pointers 0, axis_out_tvalid=0, credit_out=0, overflow=0, pkt_count=0; axis_out_tdata/tid/tdest/tlast don't-care while tvalid=0. Flits presented during reset are discarded and no credits are returned for them; upstream must be reset together.
- Reset mid-packet: buffer contents lost; no partial-packet completion.
- Latency send_in -> axis_out_tvalid: 1 cycle (flit at edge t visible after edge t).
- Pop at edge t -> credit_out high for the cycle after edge t, exactly one pulse per pop; back-to-back pops give back-to-back pulses.
- Credit loop: slot freed at t can be refilled no earlier than t+2 from the sender side; throughput 1 flit/cycle sustained with DEPTH>=2 (>=3 needed for full rate with a 1-cycle link pipeline).
- All outputs registered or derived from registered state; no combinational path from send_in or axis_out_tready to any output except through flops.

## Structure
- Shared package noc_link_pkg: flit_t struct {data, dest, is_tail} parameterized via localparams, DEST split helper functions get_tid/get_tdest.
- One sub-module: flit_fifo (synchronous FIFO, DEPTH x flit_t, full/empty/count); top holds credit, overflow, pkt_count logic and AXIS mapping.

## Test plan
- Reset: hold rst_n=0 3 cycles with send_in=1 -> tvalid=0, credit_out=0, overflow=0, pkt_count=0; after release no beats emitted.
- Single packet: 4 flits data 0xA0..0xA3, dest 0x2B, tail on 4th, tready=1 -> beats 1 cycle later, tid=2, tdest=0xB, tlast only on 0xA3, 4 credit pulses, pkt_count=1.
- Backpressure: tready=0, send 8 flits -> count=8, no credits, no overflow, data stable; raise tready -> 8 beats in order, 8 consecutive credit pulses.
- Overflow: with 8 stored and tready=0, send 9th flit (0xFF) -> overflow=1 sticky, 0xFF never appears at output.
- Full + simultaneous pop/push: buffer full, tready=1 and send_in=1 same cycle -> pop succeeds, push dropped, overflow=1.
- Streaming with credit-tracking sender model (8 initial credits), random tready 50% for 1000 flits -> no overflow, output sequence equals input, pkt_count equals tails sent.
